// File: rtl/sender_msg_streamer_pkg.sv
// Shared types and elaboration helpers for the OT sender message streamer.
package sender_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TREE,
    S_FETCH,
    S_LOAD,
    S_STREAM,
    S_DONE
  } stream_state_t;

  // Number of messages packed in one RAM row.
  function automatic int unsigned lanes_f(input int unsigned msg_w, input int unsigned row_w);
    return (msg_w == 0) ? 0 : row_w / msg_w;
  endfunction

  // Width of a lane selector; at least one bit so single-lane rows still get a port.
  function automatic int unsigned lane_w_f(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Row must hold a whole, power-of-two number of messages.
  function automatic bit cfg_ok_f(input int unsigned msg_w, input int unsigned row_w);
    int unsigned l;
    if (msg_w == 0) return 1'b0;
    l = row_w / msg_w;
    return ((row_w % msg_w) == 0) && (l != 0) && ((l & (l - 1)) == 0);
  endfunction

endpackage

// File: rtl/sender_msg_streamer_if.sv
// Control, RAM read and output-stream signals of the sender message streamer.
interface sender_msg_streamer_if #(
  parameter int unsigned MSG_W  = 64,
  parameter int unsigned ROW_W  = 1024,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 32
);
  logic              start;
  logic [CNT_W-1:0]  base_index;
  logic [CNT_W-1:0]  count;
  logic              abort;
  logic              tree_done;
  logic              row_rd_en;
  logic [ADDR_W-1:0] row_rd_addr;
  logic [ROW_W-1:0]  m0_row;
  logic [ROW_W-1:0]  m1_row;
  logic              out_valid;
  logic              out_ready;
  logic [MSG_W-1:0]  out_m0;
  logic [MSG_W-1:0]  out_m1;
  logic [CNT_W-1:0]  out_index;
  logic              out_last;
  logic              busy;
  logic              done;

  // Streamer side.
  modport master (
    input  start, base_index, count, abort, tree_done, m0_row, m1_row, out_ready,
    output row_rd_en, row_rd_addr, out_valid, out_m0, out_m1, out_index, out_last, busy, done
  );

  // Requester / RAM / consumer side.
  modport slave (
    output start, base_index, count, abort, tree_done, m0_row, m1_row, out_ready,
    input  row_rd_en, row_rd_addr, out_valid, out_m0, out_m1, out_index, out_last, busy, done
  );
endinterface

// File: rtl/sender_msg_streamer_lane_mux.sv
// Combinational selection of one message lane from a registered row buffer.
module msg_lane_mux
  import sender_pkg::*;
#(
  parameter  int unsigned MSG_W  = 64,
  parameter  int unsigned ROW_W  = 1024,
  localparam int unsigned LANES  = lanes_f(MSG_W, ROW_W),
  localparam int unsigned LANE_W = lane_w_f(LANES)
) (
  input  logic [ROW_W-1:0]  row_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [MSG_W-1:0]  msg_o
);

  // Lane k occupies bits [k*MSG_W +: MSG_W].
  always_comb begin
    msg_o = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_i == LANE_W'(k)) msg_o = row_i[k*MSG_W +: MSG_W];
    end
  end

endmodule

// File: rtl/sender_msg_streamer.sv
// Streams a window of (m0, m1) message pairs out of the sender RAMs, one row fetch at a time.
module sender_msg_streamer
  import sender_pkg::*;
#(
  parameter int unsigned MSG_W  = 64,
  parameter int unsigned ROW_W  = 1024,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 32
) (
  input logic                  clk,
  input logic                  rst,
  sender_msg_streamer_if.master bus
);

  localparam int unsigned LANES  = lanes_f(MSG_W, ROW_W);
  localparam int unsigned LANE_W = lane_w_f(LANES);
  localparam int unsigned SHIFT  = $clog2(LANES);
  localparam bit          CFG_OK = cfg_ok_f(MSG_W, ROW_W);

  if (!CFG_OK) begin : g_cfg_err
    $error("sender_msg_streamer: ROW_W must be a multiple of MSG_W with a power-of-two lane count");
  end

  stream_state_t     state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ROW_W-1:0]  m0_buf_q, m1_buf_q;
  logic              load_row;
  logic [LANE_W-1:0] lane;
  logic              last_lane;

  assign lane      = LANE_W'(idx_q % CNT_W'(LANES));
  assign last_lane = (lane == LANE_W'(LANES - 1));

  // All outputs decode registered state only; out_ready never reaches out_*.
  assign bus.row_rd_en   = (state_q == S_FETCH);
  assign bus.row_rd_addr = ADDR_W'(idx_q >> SHIFT);
  assign bus.out_valid   = (state_q == S_STREAM);
  assign bus.out_last    = (state_q == S_STREAM) && (rem_q == CNT_W'(1));
  assign bus.out_index   = idx_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

  msg_lane_mux #(.MSG_W(MSG_W), .ROW_W(ROW_W)) u_mux_m0 (
    .row_i  (m0_buf_q),
    .lane_i (lane),
    .msg_o  (bus.out_m0)
  );

  msg_lane_mux #(.MSG_W(MSG_W), .ROW_W(ROW_W)) u_mux_m1 (
    .row_i  (m1_buf_q),
    .lane_i (lane),
    .msg_o  (bus.out_m1)
  );

  // Next-state and index/remaining-count update; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    load_row = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.count == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = bus.base_index;
            rem_d   = bus.count;
            state_d = bus.tree_done ? S_FETCH : S_WAIT_TREE;
          end
        end
      end
      S_WAIT_TREE: if (bus.tree_done) state_d = S_FETCH;
      S_FETCH:     state_d = S_LOAD;
      S_LOAD: begin
        load_row = 1'b1;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          idx_d = idx_q + CNT_W'(1);
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
          else if (last_lane)     state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d  = S_IDLE;
      idx_d    = idx_q;
      rem_d    = rem_q;
      load_row = 1'b0;
    end
  end

  // State, index and remaining-count registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  // Row buffers capture RAM data in LOAD; abort leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m0_buf_q <= '0;
      m1_buf_q <= '0;
    end else if (load_row) begin
      m0_buf_q <= bus.m0_row;
      m1_buf_q <= bus.m1_row;
    end
  end

endmodule

// File: tb/tb_sender_msg_streamer.sv
// Self-checking bench for sender_msg_streamer: request table plus abort/reset/wait/wrap sequences.
module tb_sender_msg_streamer;
  import sender_pkg::*;

  localparam int unsigned MSG_W = 64;
  localparam int unsigned ROW_W = 1024;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned LANES = ROW_W / MSG_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start, abort, tree_done, out_ready;
  logic [CNT_W-1:0] base_index, count;
  int               sel;

  sender_msg_streamer_if #(.MSG_W(MSG_W), .ROW_W(ROW_W), .ADDR_W(6), .CNT_W(CNT_W)) bus0 ();
  sender_msg_streamer_if #(.MSG_W(MSG_W), .ROW_W(ROW_W), .ADDR_W(2), .CNT_W(CNT_W)) bus1 ();

  assign bus0.start      = start && (sel == 0);
  assign bus1.start      = start && (sel == 1);
  assign bus0.base_index = base_index;
  assign bus1.base_index = base_index;
  assign bus0.count      = count;
  assign bus1.count      = count;
  assign bus0.abort      = abort;
  assign bus1.abort      = abort;
  assign bus0.tree_done  = tree_done;
  assign bus1.tree_done  = tree_done;
  assign bus0.out_ready  = out_ready;
  assign bus1.out_ready  = out_ready;

  sender_msg_streamer #(.MSG_W(MSG_W), .ROW_W(ROW_W), .ADDR_W(6), .CNT_W(CNT_W)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  sender_msg_streamer #(.MSG_W(MSG_W), .ROW_W(ROW_W), .ADDR_W(2), .CNT_W(CNT_W)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // RAM model: row r, lane k holds m0 = {r, k}, m1 = ~{r, k}.
  function automatic logic [ROW_W-1:0] mk_row(input logic [31:0] r, input bit inv);
    logic [ROW_W-1:0] v;
    for (int unsigned k = 0; k < LANES; k++) v[k*MSG_W +: MSG_W] = {r, 32'(k)};
    return inv ? ~v : v;
  endfunction

  always @(posedge clk) begin
    if (bus0.row_rd_en) begin
      bus0.m0_row <= mk_row(32'(bus0.row_rd_addr), 1'b0);
      bus0.m1_row <= mk_row(32'(bus0.row_rd_addr), 1'b1);
    end
    if (bus1.row_rd_en) begin
      bus1.m0_row <= mk_row(32'(bus1.row_rd_addr), 1'b0);
      bus1.m1_row <= mk_row(32'(bus1.row_rd_addr), 1'b1);
    end
  end

  typedef struct {
    logic [31:0] idx;
    logic [63:0] m0;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] cnt;
    logic [3:0]  rdy_pat;
    int          exp_first;
    int          exp_beats;
  } vec_t;

  beat_t       sbq[$];
  logic [31:0] rowq[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_hs = 0;
  int first_valid = -1;
  int n_beats = 0;
  int n_done = 0;
  int done_cyc = -1;
  bit prev_valid = 1'b0;
  bit prev_hs = 1'b0;

  logic        o_valid, o_last, o_busy, o_done, o_rd_en;
  logic [31:0] o_addr, o_index;
  logic [63:0] o_m0, o_m1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_valid = bus0.out_valid; o_last = bus0.out_last; o_busy = bus0.busy;
      o_done = bus0.done; o_rd_en = bus0.row_rd_en; o_addr = 32'(bus0.row_rd_addr);
      o_index = bus0.out_index; o_m0 = bus0.out_m0; o_m1 = bus0.out_m1;
    end else begin
      o_valid = bus1.out_valid; o_last = bus1.out_last; o_busy = bus1.busy;
      o_done = bus1.done; o_rd_en = bus1.row_rd_en; o_addr = 32'(bus1.row_rd_addr);
      o_index = bus1.out_index; o_m0 = bus1.out_m0; o_m1 = bus1.out_m1;
    end
  endtask

  // Expected beats and row fetches for a request on the selected instance.
  task automatic push_expect(input logic [31:0] b, input logic [31:0] c);
    logic [31:0] idx, r, dep;
    beat_t       bt;
    dep = (sel == 0) ? 32'd64 : 32'd4;
    for (int unsigned i = 0; i < c; i++) begin
      idx     = b + 32'(i);
      r       = (idx / LANES) % dep;
      bt.idx  = idx;
      bt.m0   = {r, idx % LANES};
      bt.last = (i == c - 1);
      sbq.push_back(bt);
      if (i == 0 || (idx % LANES) == 0) rowq.push_back(r);
    end
  endtask

  // Checks the current cycle against the scoreboard, then advances one clock.
  task automatic step();
    bit hs;
    sample();
    hs = o_valid && out_ready;
    if (prev_valid && !prev_hs) chk("valid_held", 64'(o_valid), 64'd1);
    if (o_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (n_beats > 0 && !prev_valid) chk("refetch_gap", 64'(cyc - last_hs), 64'd3);
      if (sbq.size() == 0) begin
        chk("extra_beat", 64'(o_valid), 64'd0);
      end else begin
        chk("out_index", 64'(o_index), 64'(sbq[0].idx));
        chk("out_m0", o_m0, sbq[0].m0);
        chk("out_m1", o_m1, ~sbq[0].m0);
        chk("out_last", 64'(o_last), 64'(sbq[0].last));
      end
    end else begin
      chk("last_idle", 64'(o_last), 64'd0);
    end
    if (hs) begin
      if (sbq.size() > 0) sbq.delete(0);
      n_beats++;
      last_hs = cyc;
    end
    if (o_rd_en) begin
      if (rowq.size() == 0) chk("extra_fetch", 64'(o_rd_en), 64'd0);
      else chk("row_rd_addr", 64'(o_addr), 64'(rowq.pop_front()));
    end
    if (o_done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_valid = o_valid;
    prev_hs    = hs;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_track();
    n_beats = 0; n_done = 0; first_valid = -1; done_cyc = -1;
  endtask

  // Runs an already-started request to completion and checks its framing.
  task automatic finish_req(input int t0, input logic [31:0] c, input logic [3:0] pat,
                            input int exp_first, input int exp_beats);
    int k = 0;
    int budget = 0;
    int rel;
    while (n_done == 0 && budget < 2000) begin
      sample();
      chk("busy", 64'(o_busy), 64'd1);
      out_ready = pat[k % 4];
      if (o_valid) k++;
      step();
      budget++;
    end
    chk("done_seen", 64'(n_done), 64'd1);
    if (n_done == 1) chk("done_cycle", 64'(done_cyc), 64'((c == 0) ? t0 + 1 : last_hs + 1));
    rel = (first_valid < 0) ? -1 : first_valid - t0;
    chk("first_valid", 64'(rel), 64'(exp_first));
    chk("beats", 64'(n_beats), 64'(exp_beats));
    chk("sb_drained", 64'(sbq.size() + rowq.size()), 64'd0);
    sbq.delete();
    rowq.delete();
    step();
    sample();
    chk("busy_after", 64'(o_busy), 64'd0);
    chk("done_pulse", 64'(n_done), 64'd1);
  endtask

  task automatic run_req(input logic [31:0] b, input logic [31:0] c, input logic [3:0] pat,
                         input int exp_first, input int exp_beats);
    int t0;
    clear_track();
    push_expect(b, c);
    base_index = b;
    count      = c;
    out_ready  = pat[0];
    start      = 1'b1;
    t0         = cyc;
    step();
    start = 1'b0;
    finish_req(t0, c, pat, exp_first, exp_beats);
  endtask

  // Drives a stream and interrupts it on the lane-7 handshake with abort or reset.
  task automatic interrupt_at_lane7(input bit use_rst);
    int b = 0;
    clear_track();
    push_expect(32'd0, 32'd20);
    base_index = 32'd0;
    count      = 32'd20;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    sample();
    while (!(o_valid && o_index == 32'd7) && b < 50) begin
      step();
      sample();
      b++;
    end
    chk("reach_lane7", 64'(o_valid && o_index == 32'd7), 64'd1);
    if (use_rst) rst = 1'b0;
    else abort = 1'b1;
    step();
    rst   = 1'b1;
    abort = 1'b0;
    sbq.delete();
    rowq.delete();
    sample();
    chk("intr_valid", 64'(o_valid), 64'd0);
    chk("intr_busy", 64'(o_busy), 64'd0);
    if (use_rst) begin
      chk("rst_index", 64'(o_index), 64'd0);
      chk("rst_m0", o_m0, 64'd0);
    end
    n_done = 0;
    repeat (5) step();
    chk("intr_no_done", 64'(n_done), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int t0;
    int r;

    vecs[0] = '{base: 32'd0,          cnt: 32'd32, rdy_pat: 4'b1111, exp_first: 3,  exp_beats: 32};
    vecs[1] = '{base: 32'd13,         cnt: 32'd5,  rdy_pat: 4'b1001, exp_first: 3,  exp_beats: 5};
    vecs[2] = '{base: 32'd0,          cnt: 32'd0,  rdy_pat: 4'b1111, exp_first: -1, exp_beats: 0};
    vecs[3] = '{base: 32'd7,          cnt: 32'd3,  rdy_pat: 4'b1111, exp_first: 3,  exp_beats: 3};
    vecs[4] = '{base: 32'd15,         cnt: 32'd1,  rdy_pat: 4'b1111, exp_first: 3,  exp_beats: 1};
    vecs[5] = '{base: 32'd100,        cnt: 32'd20, rdy_pat: 4'b0101, exp_first: 3,  exp_beats: 20};
    vecs[6] = '{base: 32'd30,         cnt: 32'd18, rdy_pat: 4'b0111, exp_first: 3,  exp_beats: 18};
    vecs[7] = '{base: 32'hFFFF_FFFE,  cnt: 32'd4,  rdy_pat: 4'b1111, exp_first: 3,  exp_beats: 4};

    sel = 0; rst = 1'b0; start = 1'b0; abort = 1'b0; tree_done = 1'b1;
    out_ready = 1'b1; base_index = '0; count = '0;
    #1;

    // Reset and quiet idle.
    repeat (3) step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample();
      chk("reset_flags", 64'({o_valid, o_last, o_busy, o_done, o_rd_en}), 64'd0);
      chk("reset_addr_index", {o_addr, o_index}, 64'd0);
      chk("reset_m0_m1", o_m0 | o_m1, 64'd0);
      step();
    end

    // Request table on the default instance.
    for (int i = 0; i < 8; i++)
      run_req(vecs[i].base, vecs[i].cnt, vecs[i].rdy_pat, vecs[i].exp_first, vecs[i].exp_beats);

    // Start while the tree is incomplete, then release it.
    clear_track();
    push_expect(32'd32, 32'd4);
    tree_done  = 1'b0;
    base_index = 32'd32;
    count      = 32'd4;
    out_ready  = 1'b1;
    start      = 1'b1;
    t0         = cyc;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("wait_busy", 64'(o_busy), 64'd1);
      chk("wait_no_fetch", 64'(o_rd_en), 64'd0);
      step();
    end
    tree_done = 1'b1;
    r = cyc;
    step();
    sample();
    chk("wait_fetch_next", 64'(o_rd_en), 64'd1);
    chk("wait_fetch_cycle", 64'(cyc - r), 64'd1);
    finish_req(t0, 32'd4, 4'b1111, 14, 4);

    // Row address and index wrap on the 4-row instance.
    sel = 1;
    run_req(32'd62, 32'd4, 4'b1111, 3, 4);
    sel = 0;

    // Abort, then restart; reset, then restart.
    interrupt_at_lane7(1'b0);
    run_req(32'd40, 32'd6, 4'b1111, 3, 6);
    interrupt_at_lane7(1'b1);
    run_req(32'd16, 32'd3, 4'b1101, 3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sender_msg_streamer.md
# sender_msg_streamer

Parametrised output stage for the OT sender tree. It replaces the sender's combinational random-access `msg_index` read-out with a streaming engine. It sits between the m0/m1 message RAMs written by the tree state machine and the downstream consumer. After the tree completes, it streams a requested window of (m0, m1) message pairs over a valid/ready handshake, fetching one RAM row at a time and slicing it into lanes.

## Interface
Parameters:
- `MSG_W`, 64: bits per message.
- `ROW_W`, 1024: bits per RAM row; must be a multiple of `MSG_W`. `LANES = ROW_W/MSG_W`, and must be a power of two.
- `ADDR_W`, 6: RAM row address width; `DEPTH = 2**ADDR_W`.
- `CNT_W`, 32: width of index and count.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled in IDLE only.
- `base_index`  in  CNT_W  first message index; latched on `start`.
- `count`  in  CNT_W  number of pairs to emit; latched on `start`.
- `abort`  in  1  synchronous flush to IDLE.
- `tree_done`  in  1  level; high when the message RAMs are complete.
- `row_rd_en`  out  1  RAM read strobe.
- `row_rd_addr`  out  ADDR_W  RAM row address.
- `m0_row`, `m1_row`  in  ROW_W  RAM read data; valid one cycle after `row_rd_en`.
- `out_valid`  out  1
- `out_ready`  in  1
- `out_m0`, `out_m1`  out  MSG_W  lane slice of the current row.
- `out_index`  out  CNT_W  absolute message index of the current beat.
- `out_last`  out  1  high on the final beat.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- States: IDLE, WAIT_TREE, FETCH, LOAD, STREAM, DONE.
- IDLE:
  - `start` with `count`==0 goes to DONE; no beats are emitted.
  - `start` otherwise latches `idx`=`base_index` and `rem`=`count`. Next state is FETCH if `tree_done`, else WAIT_TREE.
- WAIT_TREE: moves to FETCH on the first cycle `tree_done`=1.
- FETCH: `row_rd_en`=1 and `row_rd_addr`=(`idx`/LANES) mod DEPTH. Next state is LOAD.
- LOAD: registers `m0_row`/`m1_row` into the row buffers. Next state is STREAM.
- STREAM:
  - `out_valid`=1.
  - `out_m0`/`out_m1` are lane `idx` mod LANES, where lane k occupies bits [k*MSG_W +: MSG_W].
  - `out_index`=`idx`; `out_last`=(`rem`==1).
  - On handshake: `idx`++ and `rem`--.
    - If `rem` was 1, go to DONE.
    - Else, if the lane was LANES-1, go to FETCH.
    - Else, stay in STREAM.
- DONE: `done`=1 for one cycle, then IDLE.
- Row address wraps modulo DEPTH; `idx` wraps modulo 2**CNT_W. Neither wrap is flagged.
- `start` outside IDLE is ignored.
- `abort` in any state returns to IDLE on the next cycle. No `done` pulse is generated, and the row buffers are not cleared. `abort` has priority over a simultaneous handshake.
- Reset (`rst`=0) has the same effect as `abort` and also zeroes every register.

## Timing
- Reset values: `out_valid`, `out_last`, `busy`, `done`, `row_rd_en` = 0; `row_rd_addr`, `out_index`, `out_m0`, `out_m1` = 0.
- `start` at cycle T with `tree_done`=1:
  - FETCH at T+1.
  - LOAD at T+2.
  - First `out_valid` at T+3.
- After a handshake on lane LANES-1 at cycle S, `out_valid` is low for S+1 and S+2 and returns at S+3. Sustained rate is LANES beats per LANES+2 cycles.
- A beat starting at `base_index` mid-row (lane ≠ 0) streams from that lane. Only the remainder of the row is emitted before the refetch.
- While `out_valid`=1 and `out_ready`=0, every `out_*` output holds stable.
- `out_valid` never drops without a handshake, except on `abort` or reset.
- `done` is asserted the cycle after the final handshake. `busy` is high through that DONE cycle.
- All outputs are registered or decoded from registered state only. There are no combinational paths from `out_ready` to `out_*`.

## Structure
- Shared package `sender_pkg` holds:
  - the `stream_state_t` enum (six states above);
  - `lanes_f(MSG_W, ROW_W)`;
  - the localparam checks (ROW_W % MSG_W == 0, LANES is a power of two).
- One sub-module, `msg_lane_mux`: parametrised by MSG_W/ROW_W. Purely combinational lane select on the row buffers; instantiated once each for m0 and m1.

## Test plan
- Reset/idle:
  - Stimulus: `rst`=0 for 3 cycles, then `rst`=1 with no `start`.
  - Required: every output stays at its reset value for 20 cycles.
- Aligned stream:
  - Stimulus: default params, `base_index`=0, `count`=32, `out_ready`=1. Row r, lane k is preloaded with m0={r,k}, m1=~{r,k}.
  - Required: first `out_valid` at T+3; `row_rd_addr` 0 then 1; a 2-cycle bubble after index 15; `out_last` on index 31; `done` one cycle later.
- Unaligned, backpressure:
  - Stimulus: `base_index`=13, `count`=5, `out_ready` toggled 1-0-0-1.
  - Required: indices 13,14,15 come from row 0 and 16,17 from row 1. Data holds stable while `out_ready`=0.
- Wait and zero count:
  - Stimulus: `start` with `tree_done`=0, then raise `tree_done` after 10 cycles.
  - Required: FETCH on the cycle after the raise; `busy` high throughout.
  - Stimulus: `count`=0.
  - Required: `done` at T+1; `out_valid` never asserted.
- Wrap:
  - Stimulus: `ADDR_W`=2, `base_index`=62, `count`=4.
  - Required: `row_rd_addr` 3 then 0; `out_index` 62..65.
- Abort/reset mid-stream:
  - Stimulus: `abort` in the same cycle as a handshake on lane 7.
  - Required: IDLE next cycle, `out_valid`=0, no `done`.
  - Stimulus: a new `start` afterwards.
  - Required: streams normally.
  - Stimulus: repeat with `rst`=0.
  - Required: same IDLE/no-`done` result.
